// File: rtl/uart_pkg.sv
// Shared definitions for mmio_uart_tx: register offsets (word index), STATUS bit
// positions and the serializer state type.
package uart_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] OFF_TOHOST  = 2'd3;

    localparam int unsigned ST_BUSY  = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_EMPTY = 2;
    localparam int unsigned ST_OVF   = 3;
    localparam int unsigned ST_COUNT = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by mmio_uart_tx; the core is master, the UART is slave.
interface mmio_uart_tx_if;

    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        sel;
    logic [31:0] mem_rdata;

    modport master (
        output mem_we, mem_re, mem_addr, mem_wdata, mem_be, sel,
        input  mem_rdata
    );

    modport slave (
        input  mem_we, mem_re, mem_addr, mem_wdata, mem_be, sel,
        output mem_rdata
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: pops a byte when idle or on the last stop cycle, then shifts
// start, 8 data bits LSB first and stop, each lasting div cycles (0 treated as 1).
module uart_tx_serializer
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] div,
    input  logic        valid,
    input  logic [7:0]  data,
    output logic        pop,
    output logic        tx,
    output logic        busy,
    output logic        busy_nxt_c
);

    uart_state_e r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shreg;
    logic        r_tx;
    logic        r_busy;

    logic [15:0] w_div;
    logic        w_bit_end;
    logic        w_pop;
    logic        w_busy_nxt;

    assign w_div      = (div == 16'd0) ? 16'd1 : div;
    assign w_bit_end  = (r_cnt == 16'd1);
    assign w_pop      = valid && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
    // Lets the parent register irq_empty in the same cycle BUSY drops.
    assign w_busy_nxt = w_pop || ((r_state != IDLE) && !((r_state == STOP) && w_bit_end));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_shreg <= 8'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            case (r_state)
                IDLE: begin
                    if (valid) begin
                        r_shreg <= data;
                        r_cnt   <= w_div;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt   <= w_div;
                        r_bit   <= 3'd0;
                        r_tx    <= r_shreg[0];
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= w_div;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shreg <= r_shreg >> 1;
                            r_tx    <= r_shreg[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (valid) begin
                            r_shreg <= data;
                            r_cnt   <= w_div;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pop        = w_pop;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign busy_nxt_c = w_busy_nxt;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: register decode, TX FIFO and serializer.
// Optional TOHOST register and test_done/test_code ports under UART_TOHOST_EN.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          irq_empty
`ifdef UART_TOHOST_EN
    ,
    output logic          test_done,
    output logic [31:0]   test_code
`endif
);

    import uart_pkg::*;

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned AW    = PTR_W - 1;

    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic             r_ovf;
    logic [15:0]      r_div;
    logic             r_irq_empty;

    logic [PTR_W-1:0] w_wptr_nxt, w_rptr_nxt, w_count;
    logic [1:0]       w_off;
    logic             w_hit, w_wr, w_rd;
    logic             w_full, w_empty, w_push_req, w_push, w_pop;
    logic             w_busy, w_busy_nxt;
    logic [31:0]      w_status;
    logic             w_unused;

    assign w_hit   = bus.sel && (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
    assign w_off   = bus.mem_addr[3:2];
    assign w_wr    = w_hit && bus.mem_we;
    assign w_rd    = w_hit && bus.mem_re;
    assign w_unused = ^{bus.mem_addr[1:0], bus.mem_be[3:2], bus.mem_wdata[31:16]};

    // Extra pointer MSB distinguishes full from empty.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_count = r_wptr - r_rptr;

    assign w_push_req = w_wr && (w_off == OFF_TXDATA) && bus.mem_be[0];
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_wptr_nxt = r_wptr + PTR_W'(w_push);
    assign w_rptr_nxt = r_rptr + PTR_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= bus.mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_ovf       <= 1'b0;
            r_div       <= DEFAULT_DIV;
            r_irq_empty <= 1'b1;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (w_off == OFF_STATUS) && bus.mem_be[0] && bus.mem_wdata[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr && (w_off == OFF_BAUDDIV) && (bus.mem_be[1:0] != 2'b00)) begin
                r_div <= bus.mem_wdata[15:0];
            end
            r_irq_empty <= (w_wptr_nxt == w_rptr_nxt) && !w_busy_nxt;
        end
    end

`ifdef UART_TOHOST_EN
    logic        r_test_done;
    logic [31:0] r_tohost;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_test_done <= 1'b0;
            r_tohost    <= 32'd0;
        end else if (w_wr && (w_off == OFF_TOHOST)) begin
            r_test_done <= 1'b1;
            r_tohost    <= bus.mem_wdata;
        end
    end

    assign test_done = r_test_done;
    assign test_code = r_tohost;
`endif

    always_comb begin
        w_status                     = 32'd0;
        w_status[ST_BUSY]            = w_busy;
        w_status[ST_FULL]            = w_full;
        w_status[ST_EMPTY]           = w_empty;
        w_status[ST_OVF]             = r_ovf;
        w_status[ST_COUNT +: PTR_W]  = w_count;
        bus.mem_rdata                = 32'd0;
        if (w_rd) begin
            case (w_off)
                OFF_STATUS:  bus.mem_rdata = w_status;
                OFF_BAUDDIV: bus.mem_rdata = {16'd0, r_div};
`ifdef UART_TOHOST_EN
                OFF_TOHOST:  bus.mem_rdata = r_tohost;
`endif
                default:     bus.mem_rdata = 32'd0;
            endcase
        end
    end

    uart_tx_serializer u_ser (
        .clk        (clk),
        .reset      (reset),
        .div        (r_div),
        .valid      (!w_empty),
        .data       (r_mem[r_rptr[AW-1:0]]),
        .pop        (w_pop),
        .tx         (tx),
        .busy       (w_busy),
        .busy_nxt_c (w_busy_nxt)
    );

    assign irq_empty = r_irq_empty;

endmodule
